// File: rtl/pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// pipe_stage_buffer
//
// Elastic inter-stage register for the RISC-V pipeline (IF/ID, ID/EX, ...).
// Holds up to DEPTH entries of NUM_FIELDS x DATA_WIDTH payload in a circular
// buffer with valid/ready handshakes on both sides. A global BUSYWAIT freezes
// all state, and FLUSH squashes everything held plus the word on the input.
// When empty, the output shows a NOP bubble (field 0 = NOP_VALUE, rest zero),
// so downstream decode never sees stale storage.
//
// Ports
//   CLK        in   rising-edge clock
//   RESET      in   asynchronous active-high reset
//   BUSYWAIT   in   global stall: no push, no pop, all state holds
//   FLUSH      in   squash held and incoming entries (overrides BUSYWAIT)
//   IN_VALID   in   upstream offers IN_DATA
//   IN_READY   out  stage accepts an entry this cycle (never depends on OUT_READY)
//   IN_DATA    in   payload, field k at [k*DATA_WIDTH +: DATA_WIDTH]
//   OUT_VALID  out  head entry present
//   OUT_READY  in   downstream consumes the head
//   OUT_DATA   out  head payload, or the bubble when empty
//   COUNT      out  number of entries held
// -----------------------------------------------------------------------------
module pipe_stage_buffer #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    NUM_FIELDS = 3,
    parameter int                    DEPTH      = 2,
    parameter logic [DATA_WIDTH-1:0] NOP_VALUE  = 32'h00000013
) (
    input  logic                             CLK,
    input  logic                             RESET,
    input  logic                             BUSYWAIT,
    input  logic                             FLUSH,
    input  logic                             IN_VALID,
    output logic                             IN_READY,
    input  logic [NUM_FIELDS*DATA_WIDTH-1:0] IN_DATA,
    output logic                             OUT_VALID,
    input  logic                             OUT_READY,
    output logic [NUM_FIELDS*DATA_WIDTH-1:0] OUT_DATA,
    output logic [$clog2(DEPTH+1)-1:0]       COUNT
);

    localparam int PAYLOAD_W = NUM_FIELDS * DATA_WIDTH;
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]     wp_q, wp_d;
    logic [PTR_W-1:0]     rp_q, rp_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PAYLOAD_W-1:0] bubble;
    logic                 full;
    logic                 push;
    logic                 pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Handshake. IN_READY looks only at local state, BUSYWAIT and FLUSH, so a
    // full DEPTH=1 stage cannot accept in the same cycle its head leaves.
    assign full      = (count_q == CNT_W'(DEPTH));
    assign IN_READY  = !full && !BUSYWAIT && !FLUSH;
    assign OUT_VALID = (count_q != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY && !BUSYWAIT && !FLUSH;
    assign COUNT     = count_q;

    // NOTE: every signal written in always_comb gets a default first; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (FLUSH) begin
            // Discard everything: the read side jumps to where the next write lands.
            count_d = '0;
            rp_d    = wp_q;
        end else begin
            // BUSYWAIT needs no branch of its own: it already forces push = pop = 0.
            if (push) wp_d = ptr_inc(wp_q);
            if (pop)  rp_d = ptr_inc(rp_q);
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // NOTE: payload storage is deliberately left out of reset; the output mux
    // never exposes an entry that has not been written since it was last freed.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wp_q] <= IN_DATA;
        end
    end

    // Bubble is addi x0,x0,0 in field 0 with the remaining fields zeroed.
    always_comb begin
        bubble                   = '0;
        bubble[DATA_WIDTH-1:0]   = NOP_VALUE;
        OUT_DATA                 = bubble;
        if (OUT_VALID) begin
            OUT_DATA = mem_q[rp_q];
        end
    end

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_buffer
//
// Drives a DEPTH=2 and a DEPTH=3 instance of pipe_stage_buffer. Directed
// stimulus exercises reset, streaming, back-pressure, BUSYWAIT, FLUSH and
// pointer wrap. A negedge monitor per instance records accepted words in a
// scoreboard queue and compares the head whenever the instance shows a valid
// entry; stimulus adds hand-computed spot checks.
// -----------------------------------------------------------------------------
module tb_pipe_stage_buffer;

    localparam int DW = 32;
    localparam int NF = 3;
    localparam int W  = DW * NF;
    localparam logic [W-1:0] BUBBLE = {32'h0, 32'h0, 32'h00000013};

    logic clk = 1'b0;
    logic rst;

    logic         bw2, fl2, iv2, ir2, ov2, or2;
    logic [W-1:0] id2, od2;
    logic [1:0]   cnt2;

    logic         bw3, fl3, iv3, ir3, ov3, or3;
    logic [W-1:0] id3, od3;
    logic [1:0]   cnt3;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] q2 [$];
    logic [W-1:0] q3 [$];
    int m2 = 0;
    int m3 = 0;

    pipe_stage_buffer #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .DEPTH(2), .NOP_VALUE(32'h00000013)) dut2 (
        .CLK(clk), .RESET(rst), .BUSYWAIT(bw2), .FLUSH(fl2),
        .IN_VALID(iv2), .IN_READY(ir2), .IN_DATA(id2),
        .OUT_VALID(ov2), .OUT_READY(or2), .OUT_DATA(od2), .COUNT(cnt2)
    );

    pipe_stage_buffer #(.DATA_WIDTH(DW), .NUM_FIELDS(NF), .DEPTH(3), .NOP_VALUE(32'h00000013)) dut3 (
        .CLK(clk), .RESET(rst), .BUSYWAIT(bw3), .FLUSH(fl3),
        .IN_VALID(iv3), .IN_READY(ir3), .IN_DATA(id3),
        .OUT_VALID(ov3), .OUT_READY(or3), .OUT_DATA(od3), .COUNT(cnt3)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [31:0] instr, input logic [31:0] pc);
        return {pc, pc + 32'd4, instr};
    endfunction

    // Scoreboard monitor for one instance (idx 0 -> DEPTH=2, idx 1 -> DEPTH=3).
    task automatic mon_step(input int idx, input int depth,
                            input logic ir, input logic ov, input logic [1:0] cnt,
                            input logic [W-1:0] od, input logic iv, input logic ordy,
                            input logic bw, input logic fl, input logic [W-1:0] id);
        int           m;
        int           qs;
        bit           exp_ir, do_pop, do_push;
        logic [W-1:0] head;
        string        tag;
        tag  = (idx == 0) ? "d2" : "d3";
        m    = (idx == 0) ? m2 : m3;
        qs   = (idx == 0) ? q2.size() : q3.size();
        head = '0;
        if (qs != 0) head = (idx == 0) ? q2[0] : q3[0];

        if (rst) begin
            check({tag, "_rst_count"}, W'(cnt), '0);
            check({tag, "_rst_valid"}, W'(ov), '0);
            check({tag, "_rst_data"}, od, BUBBLE);
            check({tag, "_rst_ready"}, W'(ir), W'(!bw && !fl));
            if (idx == 0) begin q2.delete(); m2 = 0; end
            else          begin q3.delete(); m3 = 0; end
            return;
        end

        exp_ir = (m < depth) && !bw && !fl;
        check({tag, "_in_ready"}, W'(ir), W'(exp_ir));
        check({tag, "_count"}, W'(cnt), W'(m));
        check({tag, "_out_valid"}, W'(ov), W'(m != 0));
        if (m == 0) begin
            check({tag, "_bubble"}, od, BUBBLE);
        end else if (qs == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: model holds %0d entries but queue is empty", tag, m);
        end else begin
            check({tag, "_head"}, od, head);
        end

        do_pop  = (m != 0) && ordy && !bw && !fl;
        do_push = iv && exp_ir;
        if (idx == 0) begin
            if (do_pop && q2.size() != 0) void'(q2.pop_front());
            if (do_push) q2.push_back(id);
            if (fl) q2.delete();
        end else begin
            if (do_pop && q3.size() != 0) void'(q3.pop_front());
            if (do_push) q3.push_back(id);
            if (fl) q3.delete();
        end
        if (fl) m = 0;
        else    m = m + int'(do_push) - int'(do_pop);
        if (idx == 0) m2 = m;
        else          m3 = m;
    endtask

    always @(negedge clk) begin
        mon_step(0, 2, ir2, ov2, cnt2, od2, iv2, or2, bw2, fl2, id2);
        mon_step(1, 3, ir3, ov3, cnt3, od3, iv3, or3, bw3, fl3, id3);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv2(input logic v, input logic [W-1:0] d, input logic r,
                        input logic b, input logic f);
        iv2 = v; id2 = d; or2 = r; bw2 = b; fl2 = f;
        tick();
    endtask

    initial begin
        logic [W-1:0] pa, pb, pc, pd, pe, pf, pg, ph, pi, pj, pk, pl;
        logic [15:0]  pv, pr;
        int           n, cyc;
        bit           acc;

        rst = 1'b1;
        iv2 = 0; id2 = '0; or2 = 0; bw2 = 0; fl2 = 0;
        iv3 = 0; id3 = '0; or3 = 0; bw3 = 0; fl3 = 0;
        tick();
        tick();
        check("reset_valid", W'(ov2), '0);
        check("reset_data", od2, BUBBLE);
        check("reset_ready", W'(ir2), W'(1));
        rst = 1'b0;

        // Streaming: one-cycle latency, then COUNT holds at 1.
        pa = mk(32'h00500093, 32'h0);
        drv2(1, pa, 1, 0, 0);
        check("stream_first_valid", W'(ov2), W'(1));
        check("stream_first_data", od2, {32'h0, 32'h4, 32'h00500093});
        for (int i = 1; i < 5; i++) begin
            drv2(1, mk(32'h00100113 + 32'(i), 32'(4 * i)), 1, 0, 0);
            check("stream_count", W'(cnt2), W'(1));
        end
        drv2(0, '0, 1, 0, 0);
        check("stream_drained", W'(cnt2), '0);

        // Back-pressure: fill, hold the third word upstream, then drain A,B,C.
        pa = mk(32'h00a00193, 32'h40);
        pb = mk(32'h00b00213, 32'h44);
        pc = mk(32'h00c00293, 32'h48);
        drv2(1, pa, 0, 0, 0);
        drv2(1, pb, 0, 0, 0);
        check("bp_full_count", W'(cnt2), W'(2));
        drv2(1, pc, 0, 0, 0);
        check("bp_still_full", W'(cnt2), W'(2));
        check("bp_in_ready_low", W'(ir2), '0);
        check("bp_head_a", od2, pa);
        drv2(1, pc, 1, 0, 0);
        check("bp_head_b", od2, pb);
        check("bp_count_after_pop", W'(cnt2), W'(1));
        drv2(1, pc, 1, 0, 0);
        check("bp_head_c", od2, pc);
        drv2(0, '0, 1, 0, 0);
        check("bp_drained", W'(cnt2), '0);

        // BUSYWAIT: four frozen cycles with one entry held.
        pd = mk(32'h00d00313, 32'h80);
        pe = mk(32'h00e00393, 32'h84);
        drv2(1, pd, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drv2(1, pe, 1, 1, 0);
            check("bw_count", W'(cnt2), W'(1));
            check("bw_data", od2, pd);
            check("bw_in_ready", W'(ir2), '0);
        end
        drv2(1, pe, 1, 0, 0);
        check("bw_resume_data", od2, pe);
        drv2(0, '0, 1, 0, 0);
        check("bw_drained", W'(cnt2), '0);

        // FLUSH with BUSYWAIT while full and an entry incoming.
        pf = mk(32'h00f00413, 32'hc0);
        pg = mk(32'h01000493, 32'hc4);
        ph = mk(32'h01100513, 32'hc8);
        pi = mk(32'h01200593, 32'h100);
        drv2(1, pf, 0, 0, 0);
        drv2(1, pg, 0, 0, 0);
        check("fl_pre_count", W'(cnt2), W'(2));
        drv2(1, ph, 1, 1, 1);
        check("fl_count", W'(cnt2), '0);
        check("fl_valid", W'(ov2), '0);
        check("fl_bubble", od2, BUBBLE);
        drv2(1, pi, 1, 0, 0);
        check("fl_next_valid", W'(ov2), W'(1));
        check("fl_next_data", od2, pi);
        drv2(0, '0, 1, 0, 0);

        // Asynchronous reset with two entries held.
        pj = mk(32'h01300613, 32'h140);
        pk = mk(32'h01400693, 32'h144);
        pl = mk(32'h01500713, 32'h180);
        drv2(1, pj, 0, 0, 0);
        drv2(1, pk, 0, 0, 0);
        check("rst_pre_count", W'(cnt2), W'(2));
        iv2 = 0;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_count", W'(cnt2), '0);
        check("async_rst_valid", W'(ov2), '0);
        check("async_rst_data", od2, BUBBLE);
        check("async_rst_ready", W'(ir2), W'(1));
        tick();
        rst = 1'b0;
        drv2(1, pl, 1, 0, 0);
        check("post_rst_valid", W'(ov2), W'(1));
        check("post_rst_data", od2, pl);
        drv2(0, '0, 1, 0, 0);
        check("post_rst_drained", W'(cnt2), '0);

        // DEPTH=3: ten words through mixed valid/ready patterns.
        pv  = 16'b1101_0111_1011_1111;
        pr  = 16'b1011_0110_1110_0000;
        n   = 0;
        cyc = 0;
        while (n < 10 && cyc < 60) begin
            iv3 = pv[cyc % 16];
            or3 = pr[cyc % 16];
            id3 = mk(32'h00000093 | (32'(n) << 20), 32'(n * 4));
            #1;
            acc = iv3 && ir3;
            tick();
            if (acc) n++;
            cyc++;
        end
        check("d3_all_pushed", W'(n), W'(10));
        iv3 = 0;
        or3 = 1;
        for (int i = 0; i < 4; i++) tick();
        check("d3_drained", W'(cnt3), '0);
        check("d3_bubble", od3, BUBBLE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
